dmem_arbiter: RTL and testbench

Shares the single data-memory port between the RISCV core and a host/debug requester, such as a bench loader or a future DMA. It sits between the core's DataMem* pins and the data memory. Memory reads are combinational, so read data returns in the same cycle. The core has priority, and the host is guaranteed a grant within a bounded wait. When the host owns the port, the core receives a stall.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arb_ctrl.sv | 94 +++++++++
 rtl/dmem_arbiter.sv | 79 +++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WAIT  = 8;
  localparam int DEF_MAX_BURST = 4;

  // Owner of the memory port; plain constants so older netlists keep the same encoding.
  typedef logic [0:0] owner_t;
  localparam owner_t S_CPU  = 1'b0;
  localparam owner_t S_HOST = 1'b1;

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, host and memory sides of the data-memory arbiter. The arbiter uses the
// slave view; whatever surrounds it (core, host, memory) uses the master view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] CpuAddr;
  logic              CpuRead;
  logic              CpuWrite;
  logic [DATA_W-1:0] CpuWData;
  logic [DATA_W-1:0] CpuRData;
  logic              CpuStall;

  logic              HostReq;
  logic              HostWrite;
  logic [ADDR_W-1:0] HostAddr;
  logic [DATA_W-1:0] HostWData;
  logic              HostGnt;
  logic [DATA_W-1:0] HostRData;
  logic              HostRValid;

  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  modport slave (
    input  CpuAddr, CpuRead, CpuWrite, CpuWData,
    input  HostReq, HostWrite, HostAddr, HostWData,
    input  MemRData,
    output CpuRData, CpuStall,
    output HostGnt, HostRData, HostRValid,
    output MemAddr, MemRead, MemWrite, MemWData
  );

  modport master (
    output CpuAddr, CpuRead, CpuWrite, CpuWData,
    output HostReq, HostWrite, HostAddr, HostWData,
    output MemRData,
    input  CpuRData, CpuStall,
    input  HostGnt, HostRData, HostRValid,
    input  MemAddr, MemRead, MemWrite, MemWData
  );

endinterface

// File: rtl/dmem_arb_ctrl.sv
// Owner FSM for the data-memory port: the core has priority, a waiting host is
// forced in after MAX_WAIT lost cycles, and a host tenure is capped while the core is busy.
module dmem_arb_ctrl
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   CpuRead,
  input  logic   CpuWrite,
  input  logic   HostReq,
  output owner_t Owner,
  output logic   HostGnt,
  output logic   CpuStall
);

  localparam int WAIT_W  = cntWidth(MAX_WAIT);
  localparam int BURST_W = cntWidth(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);

  owner_t             state_r;
  owner_t             stateNext_s;
  logic [WAIT_W-1:0]  waitCnt_r;
  logic [WAIT_W-1:0]  waitCntNext_s;
  logic [BURST_W-1:0] burstCnt_r;
  logic [BURST_W-1:0] burstCntNext_s;
  logic               cpuActive_s;

  assign cpuActive_s = CpuRead | CpuWrite;
  assign Owner       = state_r;

  // Ownership decision, counter updates and the grant/stall outputs
  always_comb begin
    stateNext_s    = state_r;
    waitCntNext_s  = waitCnt_r;
    burstCntNext_s = burstCnt_r;
    HostGnt        = 1'b0;
    CpuStall       = 1'b0;
    case (state_r)
      S_CPU: begin
        burstCntNext_s = '0;
        if (HostReq && (!cpuActive_s || (waitCnt_r == WAIT_LAST))) begin
          stateNext_s   = S_HOST;
          waitCntNext_s = '0;
        end else if (HostReq) begin
          waitCntNext_s = (waitCnt_r == WAIT_MAX) ? waitCnt_r : waitCnt_r + WAIT_W'(1);
        end else begin
          // A withdrawn request forfeits the cycles it already waited.
          waitCntNext_s = '0;
        end
      end
      S_HOST: begin
        HostGnt       = HostReq;
        CpuStall      = cpuActive_s;
        waitCntNext_s = '0;
        if (!HostReq) begin
          stateNext_s    = S_CPU;
          burstCntNext_s = '0;
        end else if (cpuActive_s && (burstCnt_r >= BURST_LAST)) begin
          stateNext_s    = S_CPU;
          burstCntNext_s = '0;
        end else if (burstCnt_r != BURST_MAX) begin
          burstCntNext_s = burstCnt_r + BURST_W'(1);
        end else begin
          burstCntNext_s = burstCnt_r;
        end
      end
      default: begin
        stateNext_s    = S_CPU;
        waitCntNext_s  = '0;
        burstCntNext_s = '0;
      end
    endcase
  end

  // Owner state and arbitration counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= S_CPU;
      waitCnt_r  <= '0;
      burstCnt_r <= '0;
    end else begin
      state_r    <= stateNext_s;
      waitCnt_r  <= waitCntNext_s;
      burstCnt_r <= burstCntNext_s;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core and a host requester.
// The memory mux is combinational from the owner; host load data is registered.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  owner_t            owner_s;
  logic              hostGnt_s;
  logic              cpuStall_s;
  logic [ADDR_W-1:0] memAddr_s;
  logic [DATA_W-1:0] memWData_s;
  logic              memRead_s;
  logic              memWrite_s;
  logic [DATA_W-1:0] hostRData_r;
  logic              hostRValid_r;

  dmem_arb_ctrl #(
    .MAX_WAIT  (MAX_WAIT),
    .MAX_BURST (MAX_BURST)
  ) u_ctrl (
    .CLK      (CLK),
    .RST      (RST),
    .CpuRead  (bus.CpuRead),
    .CpuWrite (bus.CpuWrite),
    .HostReq  (bus.HostReq),
    .Owner    (owner_s),
    .HostGnt  (hostGnt_s),
    .CpuStall (cpuStall_s)
  );

  // Memory port mux selected by the current owner
  always_comb begin
    if (owner_s == S_HOST) begin
      memAddr_s  = bus.HostAddr;
      memWData_s = bus.HostWData;
      memRead_s  = bus.HostReq & ~bus.HostWrite;
      memWrite_s = bus.HostReq & bus.HostWrite;
    end else begin
      memAddr_s  = bus.CpuAddr;
      memWData_s = bus.CpuWData;
      memRead_s  = bus.CpuRead;
      memWrite_s = bus.CpuWrite;
    end
  end

  // Capture host load data at the edge that completes a read beat
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hostRData_r  <= '0;
      hostRValid_r <= 1'b0;
    end else if (hostGnt_s && !bus.HostWrite) begin
      hostRData_r  <= bus.MemRData;
      hostRValid_r <= 1'b1;
    end else begin
      hostRData_r  <= hostRData_r;
      hostRValid_r <= 1'b0;
    end
  end

  assign bus.MemAddr    = memAddr_s;
  assign bus.MemWData   = memWData_s;
  assign bus.MemRead    = memRead_s;
  assign bus.MemWrite   = memWrite_s;
  assign bus.CpuRData   = bus.MemRData;
  assign bus.CpuStall   = cpuStall_s;
  assign bus.HostGnt    = hostGnt_s;
  assign bus.HostRData  = hostRData_r;
  assign bus.HostRValid = hostRValid_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: an ownership-level model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 4;

  logic CLK;
  logic RST;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_WAIT  (MAX_WAIT),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Data memory: combinational read, write at the rising edge.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  assign b.MemRData = mem[b.MemAddr[7:2]];
  always @(posedge CLK) begin
    if (b.MemWrite) mem[b.MemAddr[7:2]] <= b.MemWData;
  end

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how long the host has lost, beats this tenure.
  logic [31:0] refMem [0:63] = '{default: 32'h0};
  bit          mOwns   = 1'b0;
  int          mLosses = 0;
  int          mBeats  = 0;
  bit          mRValid = 1'b0;
  logic [31:0] mRData  = 32'h0;
  bit          mGnt    = 1'b0;
  bit          mStall  = 1'b0;

  always @(negedge CLK) begin : compare_p
    bit          act, eGnt, eStall, eRd, eWr;
    logic [31:0] eAddr, eWData, rdVal;
    int          idx;
    if (!RST) begin
      mOwns = 1'b0; mLosses = 0; mBeats = 0; mRValid = 1'b0; mRData = 32'h0;
    end
    act = b.CpuRead | b.CpuWrite;
    if (mOwns) begin
      eGnt = b.HostReq; eStall = act; eAddr = b.HostAddr; eWData = b.HostWData;
      eRd = b.HostReq & ~b.HostWrite; eWr = b.HostReq & b.HostWrite;
    end else begin
      eGnt = 1'b0; eStall = 1'b0; eAddr = b.CpuAddr; eWData = b.CpuWData;
      eRd = b.CpuRead; eWr = b.CpuWrite;
    end
    idx   = int'(eAddr[7:2]);
    rdVal = refMem[idx];
    check("HostGnt",    b.HostGnt,    eGnt);
    check("CpuStall",   b.CpuStall,   eStall);
    check("MemAddr",    b.MemAddr,    eAddr);
    check("MemRead",    b.MemRead,    eRd);
    check("MemWrite",   b.MemWrite,   eWr);
    check("MemWData",   b.MemWData,   eWData);
    check("CpuRData",   b.CpuRData,   rdVal);
    check("HostRValid", b.HostRValid, mRValid);
    check("HostRData",  b.HostRData,  mRData);
    mGnt   = eGnt;
    mStall = eStall;
    if (eWr) refMem[idx] = eWData;
    if (RST) begin
      mRValid = eGnt & ~b.HostWrite;
      if (mRValid) mRData = rdVal;
      if (!mOwns) begin
        if (b.HostReq) begin
          if (!act || mLosses == MAX_WAIT - 1) begin
            mOwns = 1'b1; mLosses = 0; mBeats = 0;
          end else begin
            mLosses++;
          end
        end else begin
          mLosses = 0;
        end
      end else if (!b.HostReq) begin
        mOwns = 1'b0;
      end else begin
        mBeats++;
        if (act && mBeats >= MAX_BURST) mOwns = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle(input int n);
    b.CpuRead = 1'b0; b.CpuWrite = 1'b0; b.HostReq = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic newHostBeat();
    logic [5:0] ri;
    ri = 6'($urandom_range(63));
    b.HostReq   = 1'b1;
    b.HostWrite = 1'($urandom_range(1));
    b.HostAddr  = {24'h0, ri, 2'b00};
    b.HostWData = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, nChecks %0d", nChecks);
    $fatal(1);
  end

  initial begin
    int n, k, pct, r;
    bit got;
    int gc [0:5];
    logic [5:0] ri;

    RST = 1'b1;
    b.CpuAddr = 32'h0; b.CpuRead = 1'b0; b.CpuWrite = 1'b0; b.CpuWData = 32'h0;
    b.HostReq = 1'b0; b.HostWrite = 1'b0; b.HostAddr = 32'h0; b.HostWData = 32'h0;
    #2 RST = 1'b0;
    tick(); tick();
    settle();
    check("lit_rst_gnt",    b.HostGnt,    1'b0);
    check("lit_rst_stall",  b.CpuStall,   1'b0);
    check("lit_rst_rvalid", b.HostRValid, 1'b0);
    check("lit_rst_rdata",  b.HostRData,  32'h0);
    tick();
    RST = 1'b1;
    tick();

    // Core alone: the loop's stores, plus the word a later host load expects.
    for (int i = 0; i < 5; i++) begin
      b.CpuWrite = 1'b1;
      b.CpuAddr  = (i < 4) ? 32'(16 * i) : 32'h8;
      b.CpuWData = (i < 4) ? 32'(i + 2) : 32'h1234;
      settle();
      check("lit_core_stall", b.CpuStall, 1'b0);
      tick();
    end
    b.CpuWrite = 1'b0;
    settle();
    check("lit_mem0",  mem[0],  32'd2);
    check("lit_mem16", mem[4],  32'd3);
    check("lit_mem32", mem[8],  32'd4);
    check("lit_mem48", mem[12], 32'd5);
    check("lit_mem8",  mem[2],  32'h1234);
    idle(2);

    // Host write with the core idle.
    b.HostReq = 1'b1; b.HostWrite = 1'b1; b.HostAddr = 32'h40; b.HostWData = 32'hDEAD;
    settle();
    check("lit_hw_gnt0", b.HostGnt, 1'b0);
    tick(); settle();
    check("lit_hw_gnt1", b.HostGnt, 1'b1);
    tick();
    b.HostReq = 1'b0;
    settle();
    check("lit_hw_mem", mem[16], 32'hDEAD);
    idle(2);

    // Host read of the preloaded word.
    b.HostReq = 1'b1; b.HostWrite = 1'b0; b.HostAddr = 32'h8;
    tick(); settle();
    check("lit_hr_gnt", b.HostGnt, 1'b1);
    tick();
    b.HostReq = 1'b0;
    settle();
    check("lit_hr_rvalid", b.HostRValid, 1'b1);
    check("lit_hr_rdata",  b.HostRData,  32'h1234);
    tick(); settle();
    check("lit_hr_pulse", b.HostRValid, 1'b0);
    idle(2);

    // Starvation bound with the core loading every cycle.
    b.CpuRead = 1'b1; b.CpuAddr = 32'h0;
    tick();
    b.HostReq = 1'b1; b.HostWrite = 1'b1; b.HostAddr = 32'h80; b.HostWData = 32'hBEEF;
    n = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      settle();
      if (b.HostGnt) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("lit_starve_latency", n, 8);
    check("lit_starve_stall", b.CpuStall, 1'b1);
    tick();
    b.HostReq = 1'b0;
    tick();
    idle(2);

    // Burst cap: six back-to-back host writes against a busy core.
    b.CpuRead = 1'b1; b.CpuAddr = 32'h4;
    tick();
    k = 0;
    for (int i = 0; i < 6; i++) gc[i] = -100;
    b.HostReq = 1'b1; b.HostWrite = 1'b1; b.HostAddr = 32'h60; b.HostWData = 32'hA0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      settle();
      if (b.HostGnt) begin
        gc[k] = c;
        k++;
      end
      tick();
      if (k < 6) begin
        b.HostAddr  = 32'h60 + 32'(4 * k);
        b.HostWData = 32'hA0 + 32'(k);
      end else begin
        b.HostReq = 1'b0;
      end
    end
    check("lit_burst_beats", k, 6);
    check("lit_burst_first", gc[0], 8);
    check("lit_burst_run4",  gc[3] - gc[0], 3);
    check("lit_burst_gap",   gc[4] - gc[3] - 1, 8);
    check("lit_burst_run2",  gc[5] - gc[4], 1);
    idle(2);

    // Reset asserted while host beat 2 is on the bus.
    b.HostReq = 1'b1; b.HostWrite = 1'b0; b.HostAddr = 32'h8;
    tick(); settle();
    check("lit_rb_gnt1", b.HostGnt, 1'b1);
    tick();
    RST = 1'b0;
    b.HostWrite = 1'b1; b.HostAddr = 32'hC0; b.HostWData = 32'h5555;
    b.CpuRead = 1'b1; b.CpuAddr = 32'h10;
    settle();
    check("lit_rb_gnt",    b.HostGnt,    1'b0);
    check("lit_rb_rvalid", b.HostRValid, 1'b0);
    check("lit_rb_rdata",  b.HostRData,  32'h0);
    check("lit_rb_stall",  b.CpuStall,   1'b0);
    check("lit_rb_memrd",  b.MemRead,    1'b1);
    tick();
    RST = 1'b1;
    b.HostReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lit_rb_run", b.CpuStall, 1'b0);
      tick();
    end
    check("lit_rb_nowrite", mem[48], 32'h0);
    idle(2);

    // Randomized traffic with varying core load and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (cyc / 500)
        0: pct = 90;
        1: pct = 30;
        2: pct = 100;
        3: pct = 0;
        4: pct = 60;
        default: pct = 95;
      endcase
      if (!mStall) begin
        r  = int'($urandom_range(99));
        ri = 6'($urandom_range(63));
        b.CpuRead  = (r < pct) && r[0];
        b.CpuWrite = (r < pct) && !r[0];
        b.CpuAddr  = {24'h0, ri, 2'b00};
        b.CpuWData = $urandom;
      end
      if (b.HostReq) begin
        if (mGnt) begin
          if ($urandom_range(99) < 70) newHostBeat();
          else b.HostReq = 1'b0;
        end
      end else if ($urandom_range(99) < 30) begin
        newHostBeat();
      end
      if (cyc % 700 == 350) RST = 1'b0;
      if (cyc % 700 == 352) RST = 1'b1;
      tick();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
